// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_prefetch
//  Description : Instruction-fetch stage feeding a single-cycle core. Keeps a
//                sequential prefetch stream running against an external
//                instruction memory (req/ack handshake, one request in
//                flight) and buffers up to DEPTH words. A non-sequential pc
//                flushes the buffer and restarts fetching at the new pc.
//  Ports       : clk, reset (async, active-low)
//                pc, hold                 - core side request / no-consume
//                instr, instr_valid, stall - core side response
//                imem_req, imem_addr      - registered memory request
//                imem_ack, imem_rdata     - memory completion / data
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        hold,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   head_addr_q, head_addr_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   buf_q [DEPTH];
  logic [31:0]   buf_d [DEPTH];

  logic          hit;
  logic          mismatch;
  logic          pop;
  logic          push;
  logic          ack;
  logic          waiting;
  logic [31:0]   new_addr;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, pc[1:0]};

  // An ack only counts for a request we actually have on the bus.
  assign ack      = imem_ack && req_q;
  assign waiting  = req_q && !imem_ack;
  assign mismatch = (pc[31:2] != head_addr_q[31:2]);
  assign hit      = !mismatch && (count_q != '0);
  assign pop      = hit && !hold;
  assign push     = ack && (state_q == ST_RUN) && !mismatch;
  assign new_addr = {pc[31:2], 2'b00};

  assign instr_valid = hit;
  assign stall       = ~hit;
  assign instr       = hit ? buf_q[rd_ptr_q] : 32'h0;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;

  always_comb begin
    state_d      = state_q;
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    req_d        = req_q;
    addr_d       = addr_q;
    buf_d        = buf_q;

    if (push) begin
      buf_d[wr_ptr_q] = imem_rdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      fetch_addr_d    = fetch_addr_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      head_addr_d = head_addr_q + 32'd4;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (mismatch) begin
      // Branch: drop everything buffered and retarget both pointers.
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      head_addr_d  = new_addr;
      fetch_addr_d = new_addr;
      if (state_q == ST_RUN) begin
        if (waiting) begin
          // Request still in flight must complete before the bus can move.
          state_d = ST_DISCARD;
        end else begin
          req_d  = 1'b1;
          addr_d = new_addr;
        end
      end else if (ack) begin
        state_d = ST_RUN;
        req_d   = 1'b1;
        addr_d  = new_addr;
      end
    end else if (state_q == ST_RUN) begin
      if (!waiting) begin
        req_d  = (count_d < C_DEPTH);
        addr_d = fetch_addr_d;
      end
    end else if (ack) begin
      // Stale word returned: throw it away and start on the real target.
      state_d = ST_RUN;
      req_d   = 1'b1;
      addr_d  = fetch_addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      head_addr_q  <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_prefetch
//  Description : Directed self-checking bench for ifetch_prefetch. The memory
//                model acks after n_wait wait states and returns
//                addr + 32'hE000_0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        hold = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] n_wait = 32'd0;
  logic [31:0] wait_cnt = 32'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .hold       (hold),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 32'd1;
    else                       wait_cnt <= 32'd0;
  end
  assign imem_ack   = imem_req && (wait_cnt >= n_wait);
  assign imem_rdata = imem_ack ? (imem_addr + 32'hE000_0000) : 32'h0;

  // One clock: inputs change just after the edge, outputs sampled after that.
  task automatic cyc(input logic [31:0] p, input logic h);
    @(posedge clk); #1;
    pc = p; hold = h;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b want 1", stall); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
  endtask

  task automatic test_zero_wait();
    @(posedge clk); #1; reset = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_c0_req: got %b want 0", imem_req); end
    cyc(32'h0, 1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL zw_c1_req: got %b/%h want 1/0", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_c1_valid: got %b want 0", instr_valid); end
    cyc(32'h0, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL zw_c2_valid: got %b/%b want 1/0", instr_valid, stall); end
    n_cmp++; if (instr !== 32'hE000_0000) begin n_fail++; $display("FAIL zw_c2_instr: got %h want E0000000", instr); end
    for (int i = 1; i < 8; i++) begin
      cyc(32'(i * 4), 1'b0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'hE000_0000 + 32'(i * 4)) begin
        n_fail++; $display("FAIL zw_seq pc=%h: got %b/%h want 1/%h", pc, instr_valid, instr, 32'hE000_0000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_ack_mismatch();
    cyc(32'h300, 1'b0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL am_valid: got %b want 0", instr_valid); end
    n_cmp++; if (imem_ack !== 1'b1) begin n_fail++; $display("FAIL am_coincide_ack: got %b want 1", imem_ack); end
    cyc(32'h300, 1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL am_newreq: got %b/%h want 1/300", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL am_dropped: got %b want 0", instr_valid); end
    cyc(32'h300, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0300) begin n_fail++; $display("FAIL am_hit: got %b/%h want 1/E0000300", instr_valid, instr); end
  endtask

  task automatic test_wait3();
    n_wait = 32'd3;
    for (int c = 1; c <= 3; c++) begin
      cyc(32'h304, 1'b0);
      n_cmp++; if (stall !== 1'b1 || instr !== 32'h0) begin n_fail++; $display("FAIL w3_stall1 c%0d: got %b/%h want 1/0", c, stall, instr); end
      n_cmp++; if (imem_addr !== 32'h304 || imem_req !== 1'b1) begin n_fail++; $display("FAIL w3_addr1 c%0d: got %b/%h want 1/304", c, imem_req, imem_addr); end
    end
    cyc(32'h304, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0304) begin n_fail++; $display("FAIL w3_hit1: got %b/%h want 1/E0000304", instr_valid, instr); end
    n_cmp++; if (imem_addr !== 32'h308) begin n_fail++; $display("FAIL w3_addr2 c0: got %h want 308", imem_addr); end
    for (int c = 1; c <= 3; c++) begin
      cyc(32'h308, 1'b0);
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL w3_stall2 c%0d: got %b want 1", c, stall); end
      n_cmp++; if (imem_addr !== 32'h308 || imem_req !== 1'b1) begin n_fail++; $display("FAIL w3_addr2 c%0d: got %b/%h want 1/308", c, imem_req, imem_addr); end
    end
    cyc(32'h308, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0308) begin n_fail++; $display("FAIL w3_hit2: got %b/%h want 1/E0000308", instr_valid, instr); end
  endtask

  task automatic test_branch_discard();
    // Restart from reset with a 3-wait-state memory.
    @(posedge clk); #1; reset = 1'b0; pc = 32'h0; hold = 1'b0; #1; reset = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      repeat ((k == 0) ? 4 : 3) cyc(32'(k * 4), 1'b0);
      cyc(32'(k * 4), 1'b0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'hE000_0000 + 32'(k * 4)) begin
        n_fail++; $display("FAIL bd_seq pc=%h: got %b/%h want 1/%h", pc, instr_valid, instr, 32'hE000_0000 + 32'(k * 4));
      end
    end
    // pc=0x10 was just consumed; 0x14 is in flight when the core branches.
    for (int c = 22; c <= 24; c++) begin
      cyc(32'h200, 1'b0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_fail++; $display("FAIL bd_hold c%0d: got %b/%h want 1/14", c, imem_req, imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL bd_nodata c%0d: got %b/%h want 0/0", c, instr_valid, instr); end
    end
    for (int c = 25; c <= 28; c++) begin
      cyc(32'h200, 1'b0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL bd_newreq c%0d: got %b/%h want 1/200", c, imem_req, imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bd_wait c%0d: got %b want 0", c, instr_valid); end
    end
    cyc(32'h200, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0200) begin n_fail++; $display("FAIL bd_hit: got %b/%h want 1/E0000200", instr_valid, instr); end
  endtask

  task automatic test_hold_full();
    n_wait = 32'd0;
    for (int i = 0; i < 10; i++) begin
      cyc(32'h204, 1'b1);
      if (i >= 3) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hf_noreq i%0d: got %b want 0", i, imem_req); end
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0204) begin n_fail++; $display("FAIL hf_held i%0d: got %b/%h want 1/E0000204", i, instr_valid, instr); end
      end
    end
    for (int j = 0; j < 4; j++) begin
      cyc(32'h204 + 32'(j * 4), 1'b0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'hE000_0204 + 32'(j * 4)) begin
        n_fail++; $display("FAIL hf_drain j%0d: got %b/%h want 1/%h", j, instr_valid, instr, 32'hE000_0204 + 32'(j * 4));
      end
      if (j == 1) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h214) begin n_fail++; $display("FAIL hf_resume: got %b/%h want 1/214", imem_req, imem_addr); end
      end
    end
  endtask

  task automatic test_wrap();
    cyc(32'hFFFF_FFF8, 1'b0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wr_flush: got %b want 0", instr_valid); end
    cyc(32'hFFFF_FFF8, 1'b0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wr_req: got %b/%h want 1/FFFFFFF8", imem_req, imem_addr); end
    cyc(32'hFFFF_FFF8, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hDFFF_FFF8) begin n_fail++; $display("FAIL wr_f8: got %b/%h want 1/DFFFFFF8", instr_valid, instr); end
    cyc(32'hFFFF_FFFC, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hDFFF_FFFC) begin n_fail++; $display("FAIL wr_fc: got %b/%h want 1/DFFFFFFC", instr_valid, instr); end
    cyc(32'h0, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0000) begin n_fail++; $display("FAIL wr_0: got %b/%h want 1/E0000000", instr_valid, instr); end
    cyc(32'h4, 1'b0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hE000_0004) begin n_fail++; $display("FAIL wr_4: got %b/%h want 1/E0000004", instr_valid, instr); end
  endtask

  task automatic test_async_reset();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre_req: got %b want 1", imem_req); end
    #1; reset = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_addr: got %h want 0", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL ar_valid: got %b/%b want 0/1", instr_valid, stall); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL ar_instr: got %h want 0", instr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_mismatch();
    test_wait3();
    test_branch_discard();
    test_hold_full();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
